// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its read ports.
// Optional bypass is selected by the REGFILE_BYPASS_EN macro in the files that import this.
package regfile_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_NUM      = 32;

  typedef logic [REG_BUS-1:0]      word_t;
  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  localparam reg_addr_t NOP_REG_ADDR = '0;
  localparam word_t     ZERO_WORD    = '0;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WR_ENABLE    = 1'b1;
  localparam logic WR_DISABLE   = 1'b0;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: priority mux of reset, enable, r0, bypass and storage.
// The same-cycle write bypass is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic                    rst,
  input  logic                    re_i,
  input  logic [REG_ADDR_BUS-1:0] raddr_i,
  input  logic                    we_i,
  input  logic [REG_ADDR_BUS-1:0] waddr_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  input  logic [REG_BUS-1:0]      rdata_stored_i,
  output logic [REG_BUS-1:0]      rdata_o
);

`ifdef REGFILE_BYPASS_EN
  logic hit;
  assign hit = (we_i == WR_ENABLE) && (waddr_i == raddr_i) && (waddr_i != NOP_REG_ADDR);
`else
  // Write-side inputs are kept so both builds share one port list.
  logic unused_wr;
  assign unused_wr = ^{we_i, waddr_i, wdata_i};
`endif

  always_comb begin
    rdata_o = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      rdata_o = ZERO_WORD;
    end else if (re_i == READ_DISABLE) begin
      rdata_o = ZERO_WORD;
    end else if (raddr_i == NOP_REG_ADDR) begin
      rdata_o = ZERO_WORD;
`ifdef REGFILE_BYPASS_EN
    end else if (hit) begin
      rdata_o = wdata_i;
`endif
    end else begin
      rdata_o = rdata_stored_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32x32 architectural register file, one write port and two read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [REG_ADDR_BUS-1:0] waddr_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  input  logic                    re1_i,
  input  logic [REG_ADDR_BUS-1:0] raddr1_i,
  output logic [REG_BUS-1:0]      rdata1_o,
  input  logic                    re2_i,
  input  logic [REG_ADDR_BUS-1:0] raddr2_i,
  output logic [REG_BUS-1:0]      rdata2_o
);

  word_t regs_q [REG_NUM];
  word_t regs_d [REG_NUM];

  always_comb begin
    regs_d = regs_q;
    if (we_i == WR_ENABLE && waddr_i != NOP_REG_ADDR) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rd_port u_rd_port1 (
    .rst            (rst),
    .re_i           (re1_i),
    .raddr_i        (raddr1_i),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .rdata_stored_i (regs_q[raddr1_i]),
    .rdata_o        (rdata1_o)
  );

  regfile_rd_port u_rd_port2 (
    .rst            (rst),
    .re_i           (re2_i),
    .raddr_i        (raddr2_i),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .rdata_stored_i (regs_q[raddr2_i]),
    .rdata_o        (rdata2_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;

  int checks = 0;
  int errors = 0;

  regfile dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .re1_i    (re1_i),
    .raddr1_i (raddr1_i),
    .rdata1_o (rdata1_o),
    .re2_i    (re2_i),
    .raddr2_i (raddr2_i),
    .rdata2_o (rdata2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational reads settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2);
    re1_i = re1; raddr1_i = a1; re2_i = re2; raddr2_i = a2;
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b1; raddr2_i = 5'd31;
    #2;
    check("rst_forces_p1", rdata1_o, 32'h0);
    check("rst_forces_p2", rdata2_o, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    set_rd(1'b1, 5'd1, 1'b1, 5'd31);
    check("post_rst_r1", rdata1_o, 32'h0);
    check("post_rst_r31", rdata2_o, 32'h0);

    write(5'd5, 32'hDEADBEEF);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    check("r5_p1", rdata1_o, 32'hDEADBEEF);
    check("r5_p2", rdata2_o, 32'hDEADBEEF);

    set_rd(1'b0, 5'd5, 1'b1, 5'd5);
    check("re1_off_r5", rdata1_o, 32'h0);
    check("re2_on_r5", rdata2_o, 32'hDEADBEEF);

    // Write to r0 while reading r0: never visible, not even through bypass.
    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h12345678;
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    check("r0_same_cycle", rdata1_o, 32'h0);
    tick();
    we_i = 1'b0;
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    check("r0_p1", rdata1_o, 32'h0);
    check("r0_p2", rdata2_o, 32'h0);

    write(5'd31, 32'hCAFEF00D);
    write(5'd1, 32'h00000001);
    set_rd(1'b1, 5'd1, 1'b1, 5'd31);
    check("r1_p1", rdata1_o, 32'h00000001);
    check("r31_p2", rdata2_o, 32'hCAFEF00D);

    write(5'd7, 32'h11111111);
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h22222222;
    set_rd(1'b1, 5'd7, 1'b1, 5'd5);
`ifdef REGFILE_BYPASS_EN
    check("r7_same_cycle", rdata1_o, 32'h22222222);
`else
    check("r7_same_cycle", rdata1_o, 32'h11111111);
`endif
    check("r5_no_false_hit", rdata2_o, 32'hDEADBEEF);
    set_rd(1'b0, 5'd7, 1'b1, 5'd5);
    check("r7_bypass_gated_by_re", rdata1_o, 32'h0);
    tick();
    we_i = 1'b0;
    set_rd(1'b1, 5'd7, 1'b1, 5'd7);
    check("r7_next_p1", rdata1_o, 32'h22222222);
    check("r7_next_p2", rdata2_o, 32'h22222222);

    // Back-to-back writes to r3, reset arriving with a write to r4 on the fourth cycle.
    we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) tick();
    set_rd(1'b1, 5'd3, 1'b1, 5'd4);
    check("r3_streamed", rdata1_o, 32'hA5A5A5A5);
    check("r4_before", rdata2_o, 32'h0);
    rst = 1'b1; waddr_i = 5'd4; wdata_i = 32'h00000005;
    set_rd(1'b1, 5'd3, 1'b1, 5'd7);
    check("rst_mid_p1", rdata1_o, 32'h0);
    check("rst_mid_p2", rdata2_o, 32'h0);
    tick();
    rst = 1'b0; we_i = 1'b0;
    set_rd(1'b1, 5'd3, 1'b1, 5'd4);
    check("r3_after_rst", rdata1_o, 32'h0);
    check("r4_after_rst", rdata2_o, 32'h0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd31);
    check("r5_after_rst", rdata1_o, 32'h0);
    check("r31_after_rst", rdata2_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural general-purpose register file at the end of the write-back path. Accepts one write per cycle from the WB stage (address, enable, data carried down from MEM) and serves two operand read ports to the ID stage. Register 0 is hardwired to zero. Same-cycle write-to-read bypass is configurable, so the pipeline needs no WB→ID forwarding path.

## Interface
- Parameters: none. Widths come from shared constants: `REG_BUS` is 32 bits, `REG_ADDR_BUS` is 5 bits, `REG_NUM` is 32.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset (`RST_ENABLE` = 1).
- `we_i`  in  1  write enable from WB (`WR_ENABLE` / `WR_DISABLE`).
- `waddr_i`  in  `REG_ADDR_BUS`  write register index.
- `wdata_i`  in  `REG_BUS`  write data.
- `re1_i`  in  1  read port 1 enable from ID (`READ_ENABLE` / `READ_DISABLE`).
- `raddr1_i`  in  `REG_ADDR_BUS`  read port 1 index.
- `rdata1_o`  out  `REG_BUS`  read port 1 data.
- `re2_i`  in  1  read port 2 enable.
- `raddr2_i`  in  `REG_ADDR_BUS`  read port 2 index.
- `rdata2_o`  out  `REG_BUS`  read port 2 data.

## Operation
- Storage is 32 × 32-bit registers, `regs[0..31]`.
- Write path:
  - On a rising edge with `rst` low, `we_i` = 1 and `waddr_i` ≠ 0, `regs[waddr_i]` ← `wdata_i`.
  - A write to index 0 is discarded silently.
- Reset:
  - On a rising edge with `rst` high, all 32 registers clear to `ZERO_WORD`.
  - A write presented in the same cycle as reset is dropped.
- Read path is combinational. Each port is evaluated independently, with first-match priority:
  1. `rst` high → `ZERO_WORD`.
  2. Port enable low → `ZERO_WORD`.
  3. Read address = 0 → `ZERO_WORD`.
  4. Bypass hit (see Configuration) → `wdata_i`.
  5. Otherwise → `regs[raddr]`.
- Both ports may read the same index, and each receives the same value.
- Reset values of the outputs: `rdata1_o` and `rdata2_o` are `ZERO_WORD` whenever `rst` is high, regardless of any other input.

## Timing
- Write latency is one cycle: data written at edge N is visible through storage from the cycle after edge N.
- Read latency is zero cycles: output follows address, enable and storage combinationally within the cycle.
- Same-cycle write and read of the same nonzero index:
  - With bypass: the read returns the new `wdata_i`.
  - Without bypass: the read returns the old value, and the new value appears next cycle.
- Writes continue back-to-back every cycle with no bubbles; there is no backpressure.
- Reset asserted mid-stream: all registers clear at that edge. The first post-reset cycle reads zeros everywhere.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - A port hits when `we_i` = 1, `waddr_i` = its read address, and `waddr_i` ≠ 0.
  - On a hit, the port outputs `wdata_i`.
  - ID may consume a result being written back in the same cycle.
- Undefined:
  - Rule 4 is absent and reads always come from storage.
  - The hazard unit must stall ID one cycle on a WB→ID read-after-write.
- The port list is identical in both builds.

## Structure
- Shared constants are added to the common define file: `REG_BUS`, `REG_ADDR_BUS`, `REG_NUM`, `NOP_REG_ADDR` (5'b0), `ZERO_WORD`, `RST_ENABLE`, `WR_ENABLE`, `WR_DISABLE`, `READ_ENABLE`, `READ_DISABLE`.
- One sub-module, `regfile_rd_port`, implements the priority read mux including the bypass compare. It is instantiated twice, once per read port.
- Storage and the write logic stay in `regfile`.

## Test plan
- Reset, then read indices 1 and 31 with both enables high → both ports return 0x00000000.
- Write 0xDEADBEEF to r5; next cycle read r5 on port 1 and r5 on port 2 → both return 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 → 0x00000000. Also check that reading with `re1_i` = 0 at r5 → 0x00000000.
- r7 holds 0x11111111; in the same cycle write 0x22222222 to r7 and read r7:
  - With `REGFILE_BYPASS_EN` → 0x22222222.
  - Without it → 0x11111111 that cycle, then 0x22222222 the next cycle.
- Write r3 = 0xA5A5A5A5 every cycle for 4 cycles, with `rst` raised together with a write to r4 = 0x5 in the last of those cycles → afterwards r3 = 0 and r4 = 0.
